// File: rtl/ucsbece154a_fetch.sv
// Instruction fetch: one outstanding imem request, DEPTH-entry buffer towards decode, redirect flush.
// Optional feature macro UCSBECE154A_FETCH_CNT_EN adds fetch_count_o (instructions handed to decode).
module ucsbece154a_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00010000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
`ifdef UCSBECE154A_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_count_o
`endif
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ISSUE, WAIT, DROP} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc;
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic          req, push, pop, full;

    assign full    = (count == FULL_CNT);
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i && !redirect_i;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        push       = 1'b0;
        unique case (state)
            ISSUE: begin
                if (!redirect_i && !full) begin
                    req        = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    state_next = imem_valid_i ? ISSUE : DROP;
                end else if (imem_valid_i) begin
                    push       = 1'b1;
                    state_next = ISSUE;
                end
            end
            DROP: begin
                // A redirect here keeps waiting for the stale response unless it is arriving now.
                if (imem_valid_i) state_next = ISSUE;
            end
            default: state_next = ISSUE;
        endcase
    end

    // Reset is asynchronous, so the request is also masked combinationally while it is held.
    assign imem_req_o  = req && !reset;
    assign imem_addr_o = fetch_pc;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ISSUE;
            fetch_pc <= RESET_PC & ~32'd3;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (redirect_i)  fetch_pc <= redirect_pc_i & ~32'd3;
            else if (req)    fetch_pc <= fetch_pc + 32'd4;
            if (redirect_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + AW'(1);
                if (pop)  head <= head + AW'(1);
                if (push != pop) count <= push ? count + (AW+1)'(1) : count - (AW+1)'(1);
            end
        end
    end

    // NOTE: buffer storage has no reset; an entry is always written before it is read and outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[tail]    <= fetch_pc - 32'd4;
            buf_instr[tail] <= imem_rdata_i;
        end
    end

    assign instr_o = valid_o ? buf_instr[head] : '0;
    assign pc_o    = valid_o ? buf_pc[head]    : '0;

`ifdef UCSBECE154A_FETCH_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    fetch_count_o <= '0;
        else if (pop) fetch_count_o <= fetch_count_o + 32'd1;
    end
`endif

endmodule

// File: doc/ucsbece154a_fetch.md
UCSBECE154A_FETCH -- requirements
Module: ucsbece154a_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h00010000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter DEPTH, default 2, giving the instruction buffer entries (legal values: 2 and 4).
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port imem_req_o  output  1  one-cycle pulse requesting the word at imem_addr_o.
REQ-006 Port imem_addr_o  output  32  fetch address, word aligned.
REQ-007 Port imem_valid_i  input  1  response strobe for the outstanding request.
REQ-008 Port imem_rdata_i  input  32  instruction word, sampled with imem_valid_i.
REQ-009 Port redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-010 Port redirect_pc_i  input  32  new fetch target.
REQ-011 Port valid_o  output  1  buffer head holds an instruction for decode.
REQ-012 Port ready_i  input  1  decode accepts the head this cycle.
REQ-013 Port instr_o  output  32  head instruction.
REQ-014 Port pc_o  output  32  address of head instruction.

Function
REQ-015 The module SHALL keep at most one request outstanding; the FSM SHALL have states ISSUE, WAIT, DROP.
REQ-016 In ISSUE, imem_req_o SHALL assert when (buffer count + 0) < DEPTH, then the FSM moves to WAIT and the fetch PC advances by 4.
REQ-017 In WAIT, imem_valid_i SHALL push {pc, imem_rdata_i} into the buffer and return the FSM to ISSUE.
REQ-018 A request SHALL not be issued in the same cycle its response is received; minimum issue-to-issue spacing is 2 cycles.
REQ-019 valid_o SHALL equal buffer non-empty; instr_o/pc_o SHALL show the head entry; valid_o && ready_i SHALL pop one entry.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-021 When the buffer is full, ISSUE SHALL hold with imem_req_o low; no entry is ever overwritten.
REQ-022 redirect_i SHALL take priority over all other events: buffer emptied, fetch PC loaded with {redirect_pc_i[31:2],2'b00}, valid_o low the next cycle.
REQ-023 Redirect in WAIT, or coincident with imem_valid_i, SHALL move the FSM to DROP (or ISSUE if the response arrives that cycle); that response SHALL be discarded.
REQ-024 In DROP, imem_valid_i SHALL be discarded and the FSM SHALL go to ISSUE; a second redirect in DROP SHALL update the PC and remain in DROP.
REQ-025 PC arithmetic SHALL be modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.

Reset
REQ-026 Reset SHALL set: FSM=ISSUE, fetch PC=RESET_PC, buffer empty, imem_req_o=0, valid_o=0, instr_o=0, pc_o=0.
REQ-027 Reset asserted mid-request SHALL abandon the request; a later imem_valid_i with no request outstanding SHALL be ignored.
REQ-028 The first imem_req_o SHALL occur in the first cycle after reset deasserts, with imem_addr_o=RESET_PC.

Configuration
REQ-029 With UCSBECE154A_FETCH_CNT_EN defined, output fetch_count_o (32-bit) SHALL count instructions popped to decode, reset to 0, cleared on no other event, wrapping at 2^32.
REQ-030 Without UCSBECE154A_FETCH_CNT_EN, fetch_count_o and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Reset release, 1-cycle memory, ready_i=1 -> imem_addr_o 0x00010000, 0x00010004, 0x00010008 on alternate cycles; pc_o follows in order.
REQ-032 ready_i=0, DEPTH=2 -> exactly 2 requests issued, valid_o=1, imem_req_o stays 0 until ready_i rises.
REQ-033 Redirect to 0x00010043 while WAIT, response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never on instr_o; next imem_addr_o=0x00010040.
REQ-034 redirect_i coincident with imem_valid_i and with a pop -> buffer empty, response dropped, next request at redirect target.
REQ-035 Fetch PC at 0xFFFFFFFC -> next address 0x00000000.
REQ-036 With UCSBECE154A_FETCH_CNT_EN, 5 pops then reset -> fetch_count_o=5, then 0.
